// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// Data has priority; a bounded streak counter lets a waiting fetch through eventually.
module mem_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req_valid,
   output logic             i_req_ready,
   input  logic [31:0]      i_addr,
   output logic             i_rsp_valid,
   output logic [31:0]      i_rsp_data,
   input  logic             i_flush,
   input  logic             d_req_valid,
   output logic             d_req_ready,
   input  logic [31:0]      d_addr,
   input  logic             d_we,
   input  logic [2:0]       d_op,
   input  logic [31:0]      d_wdata,
   output logic             d_rsp_valid,
   output logic [31:0]      d_rsp_data,
   output logic [31:0]      mem_addr,
   output logic             mem_we,
   output logic [2:0]       mem_op,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] conflict_cnt
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IRD  = 2'd1,
      OWN_DRD  = 2'd2
   } owner_t;

   localparam logic [3:0] MaxStreak = 4'(MAX_STREAK);

   owner_t           r_owner;
   owner_t           w_ownerNext;
   logic [3:0]       r_streak;
   logic [CNT_W-1:0] r_conflictCnt;
   logic             w_fetchElig;
   logic             w_dataElig;
   logic             w_streakFull;
   logic             w_grantI;
   logic             w_grantD;

   assign w_fetchElig  = i_req_valid & ~i_flush & ~rst;
   assign w_dataElig   = d_req_valid & ~rst;
   assign w_streakFull = (r_streak == MaxStreak);
   assign w_grantI     = w_fetchElig & (~w_dataElig | w_streakFull);
   assign w_grantD     = w_dataElig & ~(w_fetchElig & w_streakFull);

   assign i_req_ready = w_grantI;
   assign d_req_ready = w_grantD;

   always_comb begin
      mem_addr  = 32'd0;
      mem_we    = 1'b0;
      mem_op    = 3'b000;
      mem_wdata = 32'd0;
      if (w_grantI) begin
         mem_addr = i_addr;
         mem_op   = 3'b010;
      end else if (w_grantD) begin
         mem_addr  = d_addr;
         mem_we    = d_we;
         mem_op    = d_op;
         mem_wdata = d_wdata;
      end
   end

   // Streak only grows while fetch is actually being held off by data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_streak <= 4'd0;
      end else if (w_grantI || !w_fetchElig) begin
         r_streak <= 4'd0;
      end else if (w_grantD && r_streak < MaxStreak) begin
         r_streak <= r_streak + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      r_owner <= w_ownerNext;
   end

   always_comb begin
      w_ownerNext = OWN_NONE;
      if (rst) begin
         w_ownerNext = OWN_NONE;
      end else if (w_grantI) begin
         w_ownerNext = OWN_IRD;
      end else if (w_grantD && !d_we) begin
         w_ownerNext = OWN_DRD;
      end
   end

   assign i_rsp_valid = (r_owner == OWN_IRD) & ~i_flush & ~rst;
   assign d_rsp_valid = (r_owner == OWN_DRD) & ~rst;
   assign i_rsp_data  = (r_owner == OWN_IRD) ? mem_rdata : 32'd0;
   assign d_rsp_data  = (r_owner == OWN_DRD) ? mem_rdata : 32'd0;

   // Contention is counted on raw request overlap, whoever wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_conflictCnt <= '0;
      end else if (i_req_valid && d_req_valid && !i_flush && !(&r_conflictCnt)) begin
         r_conflictCnt <= r_conflictCnt + 1'b1;
      end
   end

   assign conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a reference model predicts grants and memory
// port values, and a queue of expected response owners is checked one cycle later.
module tb_mem_arbiter;

   localparam int MAX_STREAK = 4;
   localparam int CNT_W      = 16;

   logic             clk;
   logic             rst;
   logic             i_req_valid;
   logic             i_req_ready;
   logic [31:0]      i_addr;
   logic             i_rsp_valid;
   logic [31:0]      i_rsp_data;
   logic             i_flush;
   logic             d_req_valid;
   logic             d_req_ready;
   logic [31:0]      d_addr;
   logic             d_we;
   logic [2:0]       d_op;
   logic [31:0]      d_wdata;
   logic             d_rsp_valid;
   logic [31:0]      d_rsp_data;
   logic [31:0]      mem_addr;
   logic             mem_we;
   logic [2:0]       mem_op;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;
   logic [CNT_W-1:0] conflict_cnt;

   int vectorCount;
   int miscompareCount;
   int mStreak;
   int mCnt;
   int expQ[$];

   mem_arbiter #(.MAX_STREAK(MAX_STREAK), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_flush(i_flush),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_we(d_we), .d_op(d_op), .d_wdata(d_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_op(mem_op), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One clock cycle: drive, let logic settle, compare against the model, then advance.
   task automatic applyStimulus(input bit rstV, input bit iv, input logic [31:0] ia, input bit fl,
                                input bit dv, input logic [31:0] da, input bit we,
                                input logic [2:0] op, input logic [31:0] wd);
      bit fe, de, gI, gD;
      int own;
      logic [31:0] expAddr, expWdata;
      logic [2:0]  expOp;
      bit          expWe;
      rst = rstV; i_req_valid = iv; i_addr = ia; i_flush = fl;
      d_req_valid = dv; d_addr = da; d_we = we; d_op = op; d_wdata = wd;
      mem_rdata = $urandom;
      #3;
      fe = iv && !fl && !rstV;
      de = dv && !rstV;
      gI = fe && (!de || mStreak == MAX_STREAK);
      gD = de && !(fe && mStreak == MAX_STREAK);
      expAddr = 32'd0; expWe = 1'b0; expOp = 3'b000; expWdata = 32'd0;
      if (gI) begin
         expAddr = ia; expOp = 3'b010;
      end else if (gD) begin
         expAddr = da; expWe = we; expOp = op; expWdata = wd;
      end
      checkOutput("i_req_ready", 64'(i_req_ready), 64'(gI));
      checkOutput("d_req_ready", 64'(d_req_ready), 64'(gD));
      checkOutput("mem_addr", 64'(mem_addr), 64'(expAddr));
      checkOutput("mem_we", 64'(mem_we), 64'(expWe));
      checkOutput("mem_op", 64'(mem_op), 64'(expOp));
      checkOutput("mem_wdata", 64'(mem_wdata), 64'(expWdata));
      checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(mCnt));
      own = expQ.pop_front();
      checkOutput("i_rsp_valid", 64'(i_rsp_valid), 64'(own == 1 && !fl && !rstV));
      checkOutput("d_rsp_valid", 64'(d_rsp_valid), 64'(own == 2 && !rstV));
      if (!rstV) begin
         checkOutput("i_rsp_data", 64'(i_rsp_data), (own == 1) ? 64'(mem_rdata) : 64'd0);
         checkOutput("d_rsp_data", 64'(d_rsp_data), (own == 2) ? 64'(mem_rdata) : 64'd0);
      end
      expQ.push_back(rstV ? 0 : gI ? 1 : (gD && !we) ? 2 : 0);
      if (rstV || gI || !fe) mStreak = 0;
      else if (gD && mStreak < MAX_STREAK) mStreak++;
      if (rstV) mCnt = 0;
      else if (iv && dv && !fl && mCnt < (1 << CNT_W) - 1) mCnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 0, 3'b000, 32'd0);
   endtask

   initial begin
      vectorCount = 0; miscompareCount = 0;
      rst = 1'b1; i_req_valid = 0; i_addr = 0; i_flush = 0;
      d_req_valid = 0; d_addr = 0; d_we = 0; d_op = 0; d_wdata = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      mStreak = 0; mCnt = 0;
      expQ.push_back(0);

      // Reset held with both requesting: nothing may be granted.
      applyStimulus(1, 1, 32'h8000_0000, 0, 1, 32'h8000_1000, 1, 3'b010, 32'h1234);
      idle();

      // Fetch only, three back-to-back grants.
      repeat (3) applyStimulus(0, 1, 32'h8000_0000, 0, 0, 32'd0, 0, 3'b000, 32'd0);
      idle();

      // Load versus fetch: data first, then fetch once data drops.
      applyStimulus(0, 1, 32'h8000_0004, 0, 1, 32'h8000_1000, 0, 3'b010, 32'd0);
      applyStimulus(0, 1, 32'h8000_0004, 0, 0, 32'd0, 0, 3'b000, 32'd0);
      idle();

      // Starvation guard with continuous stores.
      for (int i = 0; i < 6; i++)
         applyStimulus(0, 1, 32'h8000_0008, 0, 1, 32'h8000_2000 + 32'(i * 4), 1, 3'b010, 32'(i));
      idle();

      // Flush in the cycle after a fetch grant, with a load in the same cycle.
      applyStimulus(0, 1, 32'h8000_000C, 0, 0, 32'd0, 0, 3'b000, 32'd0);
      applyStimulus(0, 1, 32'h8000_0010, 1, 1, 32'h8000_3000, 0, 3'b001, 32'd0);
      idle();

      // Byte store: no response afterwards.
      applyStimulus(0, 0, 32'd0, 0, 1, 32'h8000_4001, 1, 3'b000, 32'h0000_00AB);
      idle();

      // Reset arriving while a load response is pending.
      applyStimulus(0, 1, 32'h8000_0014, 0, 1, 32'h8000_5000, 0, 3'b010, 32'd0);
      applyStimulus(1, 1, 32'h8000_0014, 0, 1, 32'h8000_5000, 0, 3'b010, 32'd0);
      applyStimulus(0, 1, 32'h8000_0014, 0, 1, 32'h8000_5000, 0, 3'b010, 32'd0);
      idle();

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 300; i++)
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom,
                       $urandom_range(0, 1) == 1, 3'($urandom_range(0, 2)), $urandom);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
